writeback_stage_seq: RTL and testbench
======================================

// Module: writeback_stage_seq
// PURPOSE
//  Sequential, parametrised writeback stage: selects RD source (ALU/PC/MEMORY/COMP),
//  waits for multi-cycle data-memory returns, aligns and sign-extends sub-word loads,
//  and issues a one-cycle register-file write strobe. Sits between Memory stage and
//  RegisterFile/Fetch. Drives stall_writeback to the StateMachine while a load is
//  outstanding.
// PARAMETERS
//  XLEN         32  datapath width; legal values are 32 or 64
//  MEM_TIMEOUT  15  max cycles in WAIT_MEM before mem_err (legal range 1..255)
// PORTS
//  clk              in   1     rising-edge clock
//  rst_n            in   1     asynchronous active-low reset
//  phase_writeback  in   1     start strobe; sampled only in IDLE
//  jump_en_mw       in   1     decoded jump-enable bit
//  jump_state_mw    in   1     branch/compare result from Execute
//  use_rd_mw        in   2     00=ALU 01=PC 10=MEMORY 11=COMP
//  funct3_mw        in   3     load size/sign (RV encoding); used only when MEMORY
//  rdsel_mw         in   5     destination register
//  next_pc_mw       in   XLEN  PC+4
//  alu_out_mw       in   XLEN  ALU result; load address when MEMORY
//  mem_out_mw       in   XLEN  raw aligned memory word
//  mem_valid_mw     in   1     mem_out_mw valid this cycle
//  rddata_wr        out  XLEN  write data
//  rdsel_wr         out  5     write index
//  rd_we_wr         out  1     one-cycle write strobe
//  regdata_for_pc   out  XLEN  jump target (captured alu_out_mw)
//  jump_state_wf    out  1     jump_en_mw & jump_state_mw, captured
//  stall_writeback  out  1     high while state==WAIT_MEM
//  wb_done          out  1     one-cycle completion pulse (including error ends)
//  mem_err          out  1     one-cycle pulse on load timeout
//  misalign_err     out  1     one-cycle pulse on misaligned/illegal load
// BEHAVIOUR
//  Reset: all outputs and registers 0; state=IDLE; timeout counter 0.
//  FSM states: IDLE, WAIT_MEM, WRITE.
//  IDLE, phase_writeback=1:
//   capture rdsel, use_rd, funct3, addr[2:0], next_pc, alu_out;
//   update regdata_for_pc and jump_state_wf.
//   If use_rd != MEMORY, compute rddata and go to WRITE.
//   If use_rd == MEMORY and the load is legal and aligned, go to WAIT_MEM.
//   Otherwise pulse misalign_err and wb_done in the next cycle, return to IDLE,
//   and do not write.
//  Misaligned: LH/LHU with addr[0]!=0; LW/LWU with addr[1:0]!=0;
//   LD with addr[2:0]!=0.
//  Illegal: funct3=011/110 when XLEN=32; funct3=111 always.
//  phase_writeback outside IDLE is ignored; the captured context is not altered.
//  WAIT_MEM: stall_writeback=1 and the counter increments every cycle.
//   mem_valid_mw=1: latch the extracted load data and go to WRITE.
//   The counter reaches MEM_TIMEOUT without valid: pulse mem_err and wb_done,
//    go to IDLE, no write.
//   Valid and timeout in the same cycle: valid wins.
//  WRITE (exactly one cycle): rd_we_wr=1 and wb_done=1, then go to IDLE.
//   rd_we_wr is forced to 0 when rdsel=0; wb_done still pulses.
//   rddata_wr and rdsel_wr hold their values until the next write.
//  Latency (phase_writeback edge to rd_we_wr):
//   non-memory: 1 cycle;
//   memory: N+1 cycles, where N = cycles until mem_valid_mw.
//  Data selection:
//   ALU    -> alu_out
//   PC     -> next_pc
//   COMP   -> {XLEN-1 zeros, jump_state_mw}
//   MEMORY -> mem_out shifted right by 8*addr offset, then:
//    LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend; LD uses the full 64 bits.
//  Async reset asserted mid-load aborts: no write, no err pulse, state=IDLE.
// TESTING
//  1. use_rd=ALU, alu_out=2222_2222, rd=5, phase pulse
//     -> next cycle rd_we=1, rddata=2222_2222, rdsel=5, wb_done=1.
//  2. use_rd=COMP, jump_en=1, jump_state=1 -> rddata=0000_0001, jump_state_wf=1;
//     same stimulus with jump_en=0 -> jump_state_wf=0.
//  3. LB, addr=...3, valid after 3 cycles, mem_out=80AA_AAAA
//     -> stall high 3 cycles, rddata=FFFF_FF80;
//     same stimulus as LBU -> rddata=0000_0080.
//  4. LW, addr=...2 -> misalign_err pulse, no rd_we, stall never high.
//  5. LW, mem_valid held low, MEM_TIMEOUT=4
//     -> stall high 4 cycles, then mem_err + wb_done, no write;
//     repeat with valid arriving on cycle 4 -> write, no err.
//  6. Write to rd=0 -> rd_we stays 0, wb_done=1;
//     rst_n low while in WAIT_MEM -> all outputs 0, no pulse after release.

Source files
------------

// File: rtl/writeback_stage_seq_if.sv
// writeback_stage_seq_if
//   Bundles the Memory-stage context feeding the writeback stage and the
//   register-file / fetch / state-machine facing results it produces.
//   Ports (via modports):
//     slave  - the writeback stage: consumes *_mw inputs and phase_writeback,
//              drives rddata_wr, rdsel_wr, rd_we_wr, regdata_for_pc,
//              jump_state_wf, stall_writeback, wb_done, mem_err, misalign_err.
//     master - the surrounding pipeline (or a testbench): the mirror image.
interface writeback_stage_seq_if #(
    parameter int XLEN = 32
);
    logic            phase_writeback;
    logic            jump_en_mw;
    logic            jump_state_mw;
    logic [1:0]      use_rd_mw;
    logic [2:0]      funct3_mw;
    logic [4:0]      rdsel_mw;
    logic [XLEN-1:0] next_pc_mw;
    logic [XLEN-1:0] alu_out_mw;
    logic [XLEN-1:0] mem_out_mw;
    logic            mem_valid_mw;

    logic [XLEN-1:0] rddata_wr;
    logic [4:0]      rdsel_wr;
    logic            rd_we_wr;
    logic [XLEN-1:0] regdata_for_pc;
    logic            jump_state_wf;
    logic            stall_writeback;
    logic            wb_done;
    logic            mem_err;
    logic            misalign_err;

    modport slave (
        input  phase_writeback, jump_en_mw, jump_state_mw, use_rd_mw, funct3_mw,
               rdsel_mw, next_pc_mw, alu_out_mw, mem_out_mw, mem_valid_mw,
        output rddata_wr, rdsel_wr, rd_we_wr, regdata_for_pc, jump_state_wf,
               stall_writeback, wb_done, mem_err, misalign_err
    );

    modport master (
        output phase_writeback, jump_en_mw, jump_state_mw, use_rd_mw, funct3_mw,
               rdsel_mw, next_pc_mw, alu_out_mw, mem_out_mw, mem_valid_mw,
        input  rddata_wr, rdsel_wr, rd_we_wr, regdata_for_pc, jump_state_wf,
               stall_writeback, wb_done, mem_err, misalign_err
    );
endinterface

// File: rtl/writeback_stage_seq.sv
// writeback_stage_seq
//   Sequential writeback stage. On phase_writeback (in IDLE) it captures the
//   instruction context, selects the RD source (ALU / PC / MEMORY / COMP),
//   waits for multi-cycle data-memory returns with a timeout, aligns and
//   sign/zero-extends sub-word loads and issues a one-cycle register-file
//   write strobe.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - writeback_stage_seq_if.slave (pipeline inputs, writeback outputs)
//   Parameters:
//     XLEN         - datapath width, 32 or 64
//     MEM_TIMEOUT  - cycles allowed in WAIT_MEM before mem_err (1..255)
module writeback_stage_seq #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    writeback_stage_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_PC   = 2'b01,
        SRC_MEM  = 2'b10,
        SRC_COMP = 2'b11
    } rd_src_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;

    // captured instruction context
    logic [4:0]      rdsel_q;
    logic [2:0]      funct3_q;
    logic [2:0]      addr_q;
    logic [XLEN-1:0] regdata_for_pc_q;
    logic            jump_state_wf_q;

    // write port registers (hold until next write)
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [4:0]      wr_sel_q, wr_sel_d;
    logic            wr_load;

    // one-cycle pulse registers
    logic            we_q, we_d;
    logic            done_q, done_d;
    logic            merr_q, merr_d;
    logic            malign_q, malign_d;

    logic            capture;
    logic [XLEN-1:0] direct_data;
    logic            load_bad;
    logic [2:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Non-memory result from the live inputs, written at the capture edge.
    always_comb begin
        direct_data = bus.alu_out_mw;
        case (rd_src_t'(bus.use_rd_mw))
            SRC_PC:   direct_data = bus.next_pc_mw;
            SRC_COMP: direct_data = {{(XLEN-1){1'b0}}, bus.jump_state_mw};
            default:  direct_data = bus.alu_out_mw;
        endcase
    end

    // Illegal or misaligned load check on the live address/funct3.
    always_comb begin
        load_bad = 1'b0;
        case (bus.funct3_mw)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = bus.alu_out_mw[0];
            3'b010:         load_bad = (bus.alu_out_mw[1:0] != 2'b00);
            3'b110:         load_bad = (XLEN == 32) || (bus.alu_out_mw[1:0] != 2'b00);
            3'b011:         load_bad = (XLEN == 32) || (bus.alu_out_mw[2:0] != 3'b000);
            default:        load_bad = 1'b1;
        endcase
    end

    // Byte offset within the word: 2 bits for RV32, 3 bits for RV64.
    always_comb begin
        shamt     = (XLEN == 64) ? addr_q : {1'b0, addr_q[1:0]};
        shifted   = bus.mem_out_mw >> {shamt, 3'b000};
        load_data = shifted;
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are registered so every end condition (write, timeout,
    // misalign) shows up exactly one cycle after its deciding edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        wr_load   = 1'b0;
        wr_data_d = '0;
        wr_sel_d  = '0;
        we_d      = 1'b0;
        done_d    = 1'b0;
        merr_d    = 1'b0;
        malign_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.phase_writeback) begin
                    capture = 1'b1;
                    if (rd_src_t'(bus.use_rd_mw) != SRC_MEM) begin
                        wr_load   = 1'b1;
                        wr_data_d = direct_data;
                        wr_sel_d  = bus.rdsel_mw;
                        we_d      = (bus.rdsel_mw != 5'd0);
                        done_d    = 1'b1;
                        state_d   = WRITE;
                    end else if (!load_bad) begin
                        state_d = WAIT_MEM;
                    end else begin
                        malign_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.mem_valid_mw) begin
                    wr_load   = 1'b1;
                    wr_data_d = load_data;
                    wr_sel_d  = rdsel_q;
                    we_d      = (rdsel_q != 5'd0);
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = WRITE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    merr_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdsel_q          <= '0;
            funct3_q         <= '0;
            addr_q           <= '0;
            regdata_for_pc_q <= '0;
            jump_state_wf_q  <= 1'b0;
            wr_data_q        <= '0;
            wr_sel_q         <= '0;
            we_q             <= 1'b0;
            done_q           <= 1'b0;
            merr_q           <= 1'b0;
            malign_q         <= 1'b0;
        end else begin
            we_q     <= we_d;
            done_q   <= done_d;
            merr_q   <= merr_d;
            malign_q <= malign_d;
            if (capture) begin
                rdsel_q          <= bus.rdsel_mw;
                funct3_q         <= bus.funct3_mw;
                addr_q           <= bus.alu_out_mw[2:0];
                regdata_for_pc_q <= bus.alu_out_mw;
                jump_state_wf_q  <= bus.jump_en_mw & bus.jump_state_mw;
            end
            if (wr_load) begin
                wr_data_q <= wr_data_d;
                wr_sel_q  <= wr_sel_d;
            end
        end
    end

    assign bus.rddata_wr       = wr_data_q;
    assign bus.rdsel_wr        = wr_sel_q;
    assign bus.rd_we_wr        = we_q;
    assign bus.regdata_for_pc  = regdata_for_pc_q;
    assign bus.jump_state_wf   = jump_state_wf_q;
    assign bus.stall_writeback = (state_q == WAIT_MEM);
    assign bus.wb_done         = done_q;
    assign bus.mem_err         = merr_q;
    assign bus.misalign_err    = malign_q;

endmodule

// File: tb/tb_writeback_stage_seq.sv
// tb_writeback_stage_seq
//   Scoreboard bench for writeback_stage_seq (XLEN=32, MEM_TIMEOUT=4).
//   Each operation pushes its expected completion record; a monitor pops and
//   compares whenever the DUT signals wb_done.
module tb_writeback_stage_seq;

    localparam int TO = 4;

    typedef struct {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] data;
        logic        merr;
        logic        mal;
        logic        jwf;
        logic [31:0] pcd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    writeback_stage_seq_if #(.XLEN(32)) wb_bus ();

    writeback_stage_seq #(.XLEN(32), .MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wb_bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] mem);
        logic [31:0] sh;
        sh = mem >> (8 * addr[1:0]);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rddata"}, wb_bus.rddata_wr, 0);
        check({tag, "_rdsel"},  wb_bus.rdsel_wr, 0);
        check({tag, "_pulses"}, {wb_bus.rd_we_wr, wb_bus.wb_done, wb_bus.mem_err,
                                 wb_bus.misalign_err, wb_bus.stall_writeback}, 0);
        check({tag, "_pc"},     wb_bus.regdata_for_pc, 0);
        check({tag, "_jwf"},    wb_bus.jump_state_wf, 0);
    endtask

    // Drives one operation, pushes its expected record, and checks latency
    // and stall length. valid_at: WAIT_MEM cycle (1-based) carrying mem_valid,
    // 0 = never. poke: re-pulse phase with garbage context during cycle 1.
    task automatic run_op(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] mem,
                          input logic jen, input logic jst, input int valid_at, input bit poke);
        exp_t e;
        int   lat_exp, stall_exp, cyc, stalls;
        bit   done, bad;
        e.jwf = jen & jst; e.pcd = alu; e.sel = rd; e.data = '0;
        e.we = 1'b0; e.merr = 1'b0; e.mal = 1'b0;
        lat_exp = 1; stall_exp = 0;
        case (src)
            2'b00: begin e.data = alu; e.we = (rd != 0); end
            2'b01: begin e.data = pc;  e.we = (rd != 0); end
            2'b11: begin e.data = {31'd0, jst}; e.we = (rd != 0); end
            default: begin
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                      ((f3[1:0] == 2'b01) && alu[0]) ||
                      ((f3 == 3'b010) && (alu[1:0] != 2'b00));
                if (bad) e.mal = 1'b1;
                else if (valid_at < 1 || valid_at > TO) begin
                    e.merr = 1'b1; lat_exp = TO + 1; stall_exp = TO;
                end else begin
                    e.data = ref_load(f3, alu, mem); e.we = (rd != 0);
                    lat_exp = valid_at + 1; stall_exp = valid_at;
                end
            end
        endcase
        sb.push_back(e);
        @(posedge clk); #1;
        wb_bus.use_rd_mw = src; wb_bus.funct3_mw = f3; wb_bus.rdsel_mw = rd;
        wb_bus.alu_out_mw = alu; wb_bus.next_pc_mw = pc; wb_bus.mem_out_mw = mem;
        wb_bus.jump_en_mw = jen; wb_bus.jump_state_mw = jst; wb_bus.phase_writeback = 1'b1;
        @(posedge clk); #1;
        wb_bus.phase_writeback = 1'b0;
        if (poke) begin
            wb_bus.rdsel_mw = ~rd; wb_bus.alu_out_mw = ~alu; wb_bus.funct3_mw = f3 ^ 3'b100;
            wb_bus.use_rd_mw = 2'b00;
        end
        cyc = 1; stalls = 0; done = 1'b0;
        while (!done && cyc <= 40) begin
            wb_bus.mem_valid_mw = (cyc == valid_at);
            wb_bus.phase_writeback = poke && (cyc == 1);
            @(negedge clk);
            if (wb_bus.stall_writeback) stalls++;
            if (wb_bus.wb_done) done = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        wb_bus.mem_valid_mw = 1'b0;
        wb_bus.phase_writeback = 1'b0;
        check("done_seen", done, 1);
        check("latency", cyc, lat_exp);
        check("stall_cycles", stalls, stall_exp);
    endtask

    // Monitor: compare each completion against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb_bus.wb_done) begin
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rd_we", wb_bus.rd_we_wr, e.we);
                    check("mem_err", wb_bus.mem_err, e.merr);
                    check("misalign_err", wb_bus.misalign_err, e.mal);
                    check("jump_state_wf", wb_bus.jump_state_wf, e.jwf);
                    check("regdata_for_pc", wb_bus.regdata_for_pc, e.pcd);
                    if (e.we) begin
                        check("rddata", wb_bus.rddata_wr, e.data);
                        check("rdsel", wb_bus.rdsel_wr, e.sel);
                    end
                end
            end else if (wb_bus.rd_we_wr || wb_bus.mem_err || wb_bus.misalign_err) begin
                check("pulse_without_done",
                      {wb_bus.rd_we_wr, wb_bus.mem_err, wb_bus.misalign_err}, 0);
            end
        end
    end

    initial begin
        int pulses;
        wb_bus.phase_writeback = 1'b0; wb_bus.jump_en_mw = 1'b0; wb_bus.jump_state_mw = 1'b0;
        wb_bus.use_rd_mw = '0; wb_bus.funct3_mw = '0; wb_bus.rdsel_mw = '0;
        wb_bus.next_pc_mw = '0; wb_bus.alu_out_mw = '0; wb_bus.mem_out_mw = '0;
        wb_bus.mem_valid_mw = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // ALU source
        run_op(2'b00, 3'b000, 5'd5, 32'h2222_2222, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        check("t1_rddata", wb_bus.rddata_wr, 32'h2222_2222);
        check("t1_rdsel", wb_bus.rdsel_wr, 5);
        // COMP source with and without jump enable; PC source
        run_op(2'b11, 3'b000, 5'd7, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 1'b1, 0, 1'b0);
        check("t2_rddata", wb_bus.rddata_wr, 32'h0000_0001);
        check("t2_jwf", wb_bus.jump_state_wf, 1);
        run_op(2'b11, 3'b000, 5'd7, 32'h0000_0044, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1'b0);
        check("t2b_jwf", wb_bus.jump_state_wf, 0);
        run_op(2'b01, 3'b000, 5'd9, 32'h0, 32'h0000_2008, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        // LB / LBU at byte offset 3, valid on the third wait cycle
        run_op(2'b10, 3'b000, 5'd3, 32'h0000_1003, 32'h0, 32'h80AA_AAAA, 1'b0, 1'b0, 3, 1'b0);
        check("t3_lb", wb_bus.rddata_wr, 32'hFFFF_FF80);
        run_op(2'b10, 3'b100, 5'd3, 32'h0000_1003, 32'h0, 32'h80AA_AAAA, 1'b0, 1'b0, 3, 1'b0);
        check("t3_lbu", wb_bus.rddata_wr, 32'h0000_0080);
        // misaligned LW, illegal LD on RV32
        run_op(2'b10, 3'b010, 5'd4, 32'h0000_1002, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b0);
        run_op(2'b10, 3'b011, 5'd4, 32'h0000_1000, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b0);
        // timeout, then valid exactly on the last allowed cycle
        run_op(2'b10, 3'b010, 5'd6, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 0, 1'b0);
        run_op(2'b10, 3'b010, 5'd6, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, TO, 1'b0);
        check("t5_lw", wb_bus.rddata_wr, 32'hCAFE_F00D);
        // LH at offset 2, phase re-pulsed with garbage while waiting
        run_op(2'b10, 3'b001, 5'd12, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 1'b1, 1'b1, 2, 1'b1);
        check("t_poke_lh", wb_bus.rddata_wr, 32'hFFFF_8001);
        // write to x0
        run_op(2'b00, 3'b000, 5'd0, 32'h1111_1111, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, TO + 2)), 1'b0);
        end

        // reset during WAIT_MEM aborts the load silently
        @(posedge clk); #1;
        wb_bus.use_rd_mw = 2'b10; wb_bus.funct3_mw = 3'b010; wb_bus.rdsel_mw = 5'd8;
        wb_bus.alu_out_mw = 32'h0000_4000; wb_bus.phase_writeback = 1'b1;
        @(posedge clk); #1; wb_bus.phase_writeback = 1'b0;
        @(posedge clk); #1;
        check("rst_stall_before", wb_bus.stall_writeback, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (wb_bus.wb_done || wb_bus.rd_we_wr || wb_bus.mem_err || wb_bus.stall_writeback)
                pulses++;
        end
        check("post_reset_quiet", pulses, 0);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
